// File: rtl/gesture_pkg.sv
// Shared types and constants for the gesture debug link receiver.
package gesture_pkg;

    typedef enum logic [1:0] {
        GEST_UP    = 2'd0,
        GEST_DOWN  = 2'd1,
        GEST_LEFT  = 2'd2,
        GEST_RIGHT = 2'd3
    } gesture_t;

    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam int         MAX_WORD_LEN = 5;

    // Words are right-aligned in a 40-bit field, first character most significant,
    // matching how the parser shifts bytes into its line buffer.
    localparam logic [39:0] WORD_UP    = {24'h0, "UP"};
    localparam logic [39:0] WORD_DOWN  = {8'h0, "DOWN"};
    localparam logic [39:0] WORD_LEFT  = {8'h0, "LEFT"};
    localparam logic [39:0] WORD_RIGHT = "RIGHT";

    typedef struct packed {
        logic     hit;
        gesture_t cls;
    } match_t;

    // Length is checked as well as content so stray NUL bytes cannot alias a short word.
    function automatic match_t match_word(input logic [39:0] line, input logic [2:0] len);
        match_t m;
        m.hit = 1'b0;
        m.cls = GEST_UP;
        if (len == 3'd2 && line == WORD_UP) begin
            m.hit = 1'b1;
            m.cls = GEST_UP;
        end else if (len == 3'd4 && line == WORD_DOWN) begin
            m.hit = 1'b1;
            m.cls = GEST_DOWN;
        end else if (len == 3'd4 && line == WORD_LEFT) begin
            m.hit = 1'b1;
            m.cls = GEST_LEFT;
        end else if (len == 3'd5 && line == WORD_RIGHT) begin
            m.hit = 1'b1;
            m.cls = GEST_RIGHT;
        end
        return m;
    endfunction

endpackage

// File: rtl/uart_gesture_rx_if.sv
// Serial input and decoded gesture outputs of the gesture receiver.
interface uart_gesture_rx_if;
    logic       uart_rx;
    logic [1:0] gesture_class;
    logic       gesture_valid;
    logic       parse_error;
    logic       frame_error;

    modport master (
        input  uart_rx,
        output gesture_class,
        output gesture_valid,
        output parse_error,
        output frame_error
    );

    modport slave (
        output uart_rx,
        input  gesture_class,
        input  gesture_valid,
        input  parse_error,
        input  frame_error
    );
endinterface

// File: rtl/uart_gesture_rx_uart_rx.sv
// 8N1 UART byte receiver with mid-bit sampling, companion of uart_tx.
module uart_rx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             armed;
    logic             rx_p0;
    logic             rx_p1;

    // Two-flop synchronizer for the asynchronous serial line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_p0 <= 1'b0;
            rx_p1 <= 1'b0;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
        end
    end

    // Frame FSM: arm on idle-high, qualify start at half bit, then sample each bit centre.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            armed     <= 1'b0;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (armed && !rx_p1) begin
                        state <= RX_START;
                        armed <= 1'b0;
                    end else if (rx_p1) begin
                        armed <= 1'b1;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_idx <= 3'd0;
                        state   <= rx_p1 ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        shift <= {rx_p1, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rx_p1) begin
                            valid <= 1'b1;
                            data  <= shift;
                            // Line is already high here, so a zero-idle next start edge is caught.
                            armed <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/uart_gesture_rx.sv
// Gesture debug link receiver: UART bytes in, decoded gesture line events out.
module uart_gesture_rx
    import gesture_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 12_000_000,
    parameter int BAUD_RATE   = 115200
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_gesture_rx_if.master bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;

    typedef enum logic [1:0] {P_COLLECT, P_WAIT_LF, P_DISCARD} p_state_t;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ferr;

    p_state_t    p_state;
    logic [39:0] line_q;
    logic [2:0]  count_q;
    gesture_t    cls_q;
    logic        valid_q;
    logic        perr_q;
    logic        ferr_q;
    match_t      m;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (bus.uart_rx),
        .data      (rx_data),
        .valid     (rx_valid),
        .frame_err (rx_ferr)
    );

    assign m = match_word(line_q, count_q);

    // Line parser: collect up to five characters, decide on LF, swallow the rest of bad lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state <= P_COLLECT;
            line_q  <= 40'h0;
            count_q <= 3'd0;
            cls_q   <= GEST_UP;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= rx_ferr;
            if (rx_ferr) begin
                p_state <= P_DISCARD;
                line_q  <= 40'h0;
                count_q <= 3'd0;
            end else if (rx_valid) begin
                case (p_state)
                    P_COLLECT: begin
                        if (rx_data == ASCII_CR) begin
                            p_state <= P_WAIT_LF;
                        end else if (rx_data == ASCII_LF) begin
                            perr_q  <= 1'b1;
                            line_q  <= 40'h0;
                            count_q <= 3'd0;
                        end else if (count_q < 3'(MAX_WORD_LEN)) begin
                            line_q  <= {line_q[31:0], rx_data};
                            count_q <= count_q + 3'd1;
                        end else begin
                            perr_q  <= 1'b1;
                            p_state <= P_DISCARD;
                            line_q  <= 40'h0;
                            count_q <= 3'd0;
                        end
                    end
                    P_WAIT_LF: begin
                        if (rx_data == ASCII_LF) begin
                            if (count_q != 3'd0) begin
                                if (m.hit) begin
                                    valid_q <= 1'b1;
                                    cls_q   <= m.cls;
                                end else begin
                                    perr_q <= 1'b1;
                                end
                            end
                            p_state <= P_COLLECT;
                            line_q  <= 40'h0;
                            count_q <= 3'd0;
                        end else if (rx_data != ASCII_CR) begin
                            perr_q  <= 1'b1;
                            p_state <= P_DISCARD;
                        end
                    end
                    P_DISCARD: begin
                        if (rx_data == ASCII_LF) begin
                            p_state <= P_COLLECT;
                            line_q  <= 40'h0;
                            count_q <= 3'd0;
                        end
                    end
                    default: p_state <= P_COLLECT;
                endcase
            end
        end
    end

    assign bus.gesture_class = cls_q;
    assign bus.gesture_valid = valid_q;
    assign bus.parse_error   = perr_q;
    assign bus.frame_error   = ferr_q;
endmodule

// File: doc/uart_gesture_rx.md
# uart_gesture_rx

Receives ASCII gesture lines on a UART RX pin and decodes them back into a gesture class and a one-cycle valid pulse. It is the receiving end of the gesture debug link: it accepts exactly the strings the debug transmitter emits ("UP\r\n", "DOWN\r\n", "LEFT\r\n", "RIGHT\r\n"). It is used for host-driven gesture injection and for board-level loopback checks of the classifier output path.

## Interface
- CLK_FREQ_HZ, 12_000_000, system clock frequency
- BAUD_RATE, 115200, line rate; CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE (integer divide, 104 at defaults)
- clk  input  1  system clock, single domain
- rst_n  input  1  asynchronous, active-low reset
- uart_rx  input  1  serial line, idle high, 8N1, LSB first; asynchronous to clk
- gesture_class  output  2  0=UP, 1=DOWN, 2=LEFT, 3=RIGHT; held until the next gesture_valid
- gesture_valid  output  1  one-cycle pulse when a complete, matching line is received
- parse_error  output  1  one-cycle pulse per rejected line
- frame_error  output  1  one-cycle pulse per byte whose stop bit samples low

## Operation
- Reset: all outputs 0; parser buffer cleared; receiver in idle.
- uart_rx is passed through a 2-FF synchronizer.
- The receiver arms only after it has seen the synchronized line high for at least one cycle. This covers the reset-release case and recovery after a framing error.
- Receiver states:
  - RX_IDLE: a falling edge moves to RX_START.
  - RX_START: after CLKS_PER_BIT/2 cycles, re-sample the line. Low moves to RX_DATA; high is a glitch and returns to RX_IDLE.
  - RX_DATA: sample 8 bits, one every CLKS_PER_BIT cycles, shifting LSB first.
  - RX_STOP: sample the stop bit at mid-bit. High pulses byte_valid; low pulses frame_error. Either way, return to RX_IDLE.
- byte_valid and frame_error are never asserted in the same cycle.
- Parser: 5-byte buffer plus a 3-bit count. Matching is uppercase only.
- P_COLLECT:
  - CR moves to P_WAIT_LF.
  - Any other byte with count<5 is stored and count increments.
  - A 6th non-CR byte pulses parse_error and moves to P_DISCARD.
  - A bare LF pulses parse_error, clears the buffer and stays in P_COLLECT.
- P_WAIT_LF:
  - LF evaluates the line. An exact match pulses gesture_valid and updates gesture_class. Count=0 (empty line) is silently ignored. Any other content pulses parse_error.
  - On any LF, clear the buffer and return to P_COLLECT.
  - A repeated CR stays in P_WAIT_LF.
  - Any other byte pulses parse_error and moves to P_DISCARD.
- P_DISCARD: drop bytes until LF, then clear and go to P_COLLECT. No further error pulses are generated for that line.
- A frame_error in any parser state moves the parser to P_DISCARD and clears the buffer. It does not also pulse parse_error.

## Timing
- gesture_valid, parse_error and gesture_class update are registered. They occur 1 cycle after the internal byte_valid of the deciding byte.
- The deciding byte's stop bit is sampled CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 2 (synchronizer) cycles after its start edge.
- Back-to-back frames with zero idle are supported. Stop-bit sampling at mid-bit leaves half a bit period to detect the next start edge.
- Tolerated baud mismatch is at least ±2 %.
- Asserting rst_n mid-frame clears everything immediately. A partial line is discarded with no error pulse.

## Structure
- gesture_pkg holds:
  - gesture_t enum (GEST_UP=2'd0, GEST_DOWN, GEST_LEFT, GEST_RIGHT)
  - ASCII_CR=8'h0D, ASCII_LF=8'h0A
  - MAX_WORD_LEN=5
  - the four word constants
- Sub-module uart_rx has parameter CLKS_PER_BIT and ports clk, rst_n, rx, data[7:0], valid, frame_err. It mirrors the existing uart_tx.
- The parser FSM lives in uart_gesture_rx.

## Test plan
All scenarios run at CLKS_PER_BIT=104.
1. Send "LEFT\r\n" -> exactly one gesture_valid pulse with gesture_class=2; no parse_error or frame_error.
2. Send "UP\r\nDOWN\r\nLEFT\r\nRIGHT\r\n" back-to-back, zero idle -> four valid pulses with classes 0, 1, 2, 3 in order.
3. Send "UPX\r\n", then "up\r\n", then "DOWN\r\n" -> two parse_error pulses, then one valid pulse with class=1.
4. Send "RIGHTS\r\n", then "\r\n", then "UP\r\n":
   - one parse_error on the 'S' byte;
   - the empty line produces no pulse;
   - then valid with class=0.
5. Send 'D' with stop bit forced low, then "OWN\r\n", then "RIGHT\r\n" -> one frame_error, no parse_error; then valid with class=3.
6. Inject a 26-cycle low glitch -> no activity. Assert rst_n low in the middle of "LEFT" -> all outputs 0 while in reset. After release, "UP\r\n" gives valid with class=0.
